// File: rtl/alu_pkg.sv
// Opcode encoding and FSM state encoding for the EX-stage ALU, shared with decode.
package alu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [OPC_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [OPC_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [OPC_W-1:0] ALU_XOR   = 4'b0011;
  localparam logic [OPC_W-1:0] ALU_SLL   = 4'b0100;
  localparam logic [OPC_W-1:0] ALU_SRL   = 4'b0101;
  localparam logic [OPC_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [OPC_W-1:0] ALU_SLT   = 4'b0111;
  localparam logic [OPC_W-1:0] ALU_SRA   = 4'b1000;
  localparam logic [OPC_W-1:0] ALU_NOR   = 4'b1001;
  localparam logic [OPC_W-1:0] ALU_SLLV  = 4'b1010;
  localparam logic [OPC_W-1:0] ALU_SRLV  = 4'b1011;
  localparam logic [OPC_W-1:0] ALU_MULTU = 4'b1100;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Everything above MULTU is reserved.
  function automatic logic is_reserved(input logic [OPC_W-1:0] op);
    return op > ALU_MULTU;
  endfunction

endpackage

// File: rtl/alu_seq_core_if.sv
// Operand/result handshake bundle between the issue stage (master) and the ALU core (slave).
interface alu_seq_core_if #(
  parameter int WIDTH = 32,
  parameter int SA_W  = $clog2(WIDTH)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic [SA_W-1:0]  sa;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] resultado;
  logic [WIDTH-1:0] resultado_hi;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, a_input, b_input, sa, opcode, out_ready,
    input  in_ready, out_valid, resultado, resultado_hi, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, a_input, b_input, sa, opcode, out_ready,
    output in_ready, out_valid, resultado, resultado_hi, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles per op.
// product_nxt exposes the final sum combinationally during the last step so the caller can load it early.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_nxt
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  assign product_nxt = acc + (mplier[0] ? mcand : '0);
  assign last        = busy && (cnt == CNT_W'(WIDTH - 1));
  assign product     = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      acc    <= product_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered EX-stage ALU with valid/ready on both sides: latency 1 for single-cycle ops, WIDTH+1 for MULTU.
// A held result (out_valid & !out_ready) blocks new accepts; a draining result lets a new one load the same edge.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SA_W  = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           reset,
  alu_seq_core_if.slave bus
);
  logic [0:0]         state;
  logic               rdy_en;
  logic               slot_free;
  logic               accept;
  logic               mul_start;
  logic               load_alu;
  logic               load_mul;
  logic               mul_fin;

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   b_neg;
  logic [SA_W-1:0]    sa_var;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;

  logic               mul_busy;
  logic               mul_last;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] mul_prod_nxt;
  logic [2*WIDTH-1:0] prod;

  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   hi_q;
  logic               zero_q;
  logic               ovf_q;
  logic               ill_q;

  assign a      = bus.a_input;
  assign b      = bus.b_input;
  assign b_neg  = ~b + WIDTH'(1);
  assign sa_var = a[SA_W-1:0];

  // rdy_en keeps in_ready low through reset and until the first edge after release.
  assign slot_free    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rdy_en && (state == ST_IDLE) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.opcode == ALU_MULTU);
  assign load_alu     = accept && (bus.opcode != ALU_MULTU);

  // Either finishing this cycle, or finished earlier and parked waiting for the output slot.
  assign mul_fin  = mul_last || (mul_done && !mul_busy);
  assign load_mul = (state == ST_MUL) && mul_fin && slot_free;
  assign prod     = mul_last ? mul_prod_nxt : mul_prod;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = is_reserved(bus.opcode);
    case (bus.opcode)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_ADD: begin
        alu_res = a + b;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLL:  alu_res = b << bus.sa;
      ALU_SRL:  alu_res = b >> bus.sa;
      ALU_SUB: begin
        alu_res = a + b_neg;
        alu_ovf = (a[WIDTH-1] == b_neg[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SRA:  alu_res = $signed(b) >>> bus.sa;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_SLLV: alu_res = b << sa_var;
      ALU_SRLV: alu_res = b >> sa_var;
      default:  alu_res = '0;
    endcase
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .reset       (reset),
    .start       (mul_start),
    .a           (a),
    .b           (b),
    .busy        (mul_busy),
    .last        (mul_last),
    .done        (mul_done),
    .product     (mul_prod),
    .product_nxt (mul_prod_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rdy_en      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (load_alu) begin
        out_valid_q <= 1'b1;
        res_q       <= alu_res;
        hi_q        <= '0;
        zero_q      <= (alu_res == '0);
        ovf_q       <= alu_ovf;
        ill_q       <= alu_ill;
      end else if (load_mul) begin
        out_valid_q <= 1'b1;
        res_q       <= prod[WIDTH-1:0];
        hi_q        <= prod[2*WIDTH-1:WIDTH];
        zero_q      <= (prod[WIDTH-1:0] == '0);
        ovf_q       <= 1'b0;
        ill_q       <= 1'b0;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (mul_start) begin
        state <= ST_MUL;
      end else if (load_mul) begin
        state <= ST_IDLE;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.resultado    = res_q;
  assign bus.resultado_hi = hi_q;
  assign bus.zero         = zero_q;
  assign bus.overflow     = ovf_q;
  assign bus.illegal      = ill_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed corner cases plus randomized traffic scored against an arithmetic reference model.
module tb_alu_seq_core;

  localparam int W = 32;

  localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_ADD  = 4'd2,  OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4,  OP_SRL = 4'd5,  OP_SUB  = 4'd6,  OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8,  OP_NOR = 4'd9,  OP_SLLV = 4'd10, OP_SRLV = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         z;
    logic         v;
    logic         ill;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  logic took;
  exp_t sbq[$];

  alu_seq_core_if #(.WIDTH(W)) bus ();

  alu_seq_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] s, input logic [3:0] op);
    exp_t         e;
    longint       la;
    longint       lb;
    longint       sum;
    logic [W-1:0] bn;
    logic [63:0]  p;
    e   = '0;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    bn  = ~b + 32'd1;
    sum = 0;
    case (op)
      OP_AND:  e.lo = a & b;
      OP_OR:   e.lo = a | b;
      OP_ADD: begin
        e.lo = a + b;
        sum  = la + lb;
        e.v  = (sum > SMAX) || (sum < SMIN);
      end
      OP_XOR:  e.lo = a ^ b;
      OP_SLL:  e.lo = b << s;
      OP_SRL:  e.lo = b >> s;
      OP_SUB: begin
        e.lo = a - b;
        sum  = la + longint'($signed(bn));
        e.v  = (sum > SMAX) || (sum < SMIN);
      end
      OP_SLT:  e.lo = (la < lb) ? 32'd1 : 32'd0;
      OP_SRA:  e.lo = $unsigned($signed(b) >>> s);
      OP_NOR:  e.lo = ~(a | b);
      OP_SLLV: e.lo = b << a[4:0];
      OP_SRLV: e.lo = b >> a[4:0];
      OP_MULTU: begin
        p    = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.lo == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] s, input logic [3:0] op);
    bus.in_valid = 1'b1;
    bus.a_input  = a;
    bus.b_input  = b;
    bus.sa       = s;
    bus.opcode   = op;
  endtask

  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] s, input logic [3:0] op);
    drive(a, b, s, op);
    check(tag, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Samples both handshakes mid-cycle, then advances one clock.
  task automatic sb_cycle();
    exp_t e;
    @(negedge clk);
    took = bus.in_valid && bus.in_ready;
    if (took) sbq.push_back(model(bus.a_input, bus.b_input, bus.sa, bus.opcode));
    if (bus.out_valid && bus.out_ready) begin
      check("sb_pending", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_lo",  64'(bus.resultado),    64'(e.lo));
        check("sb_hi",  64'(bus.resultado_hi), 64'(e.hi));
        check("sb_z",   64'(bus.zero),         64'(e.z));
        check("sb_ovf", 64'(bus.overflow),     64'(e.v));
        check("sb_ill", 64'(bus.illegal),      64'(e.ill));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         bad;
    int         seen;
    logic [W-1:0] and_res;
    n_chk  = 0;
    n_pass = 0;
    took   = 1'b0;
    reset  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_input   = '0;
    bus.b_input   = '0;
    bus.sa        = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;

    #3;
    check("rst_in_ready", 64'(bus.in_ready),     64'd0);
    check("rst_out_valid", 64'(bus.out_valid),   64'd0);
    check("rst_res",      64'(bus.resultado),    64'd0);
    check("rst_hi",       64'(bus.resultado_hi), 64'd0);
    check("rst_flags",    64'({bus.zero, bus.overflow, bus.illegal}), 64'd0);
    step();
    step();
    reset = 1'b0;
    check("rdy_before_edge", 64'(bus.in_ready), 64'd0);
    step();
    check("rdy_after_edge", 64'(bus.in_ready), 64'd1);

    // SLL sweep, back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(32'd0, 32'd1, 5'(i), OP_SLL);
      check("sll_rdy", 64'(bus.in_ready), 64'd1);
      step();
      check("sll_vld", 64'(bus.out_valid), 64'd1);
      check("sll_res", 64'(bus.resultado), 64'(32'd1 << i));
      check("sll_z",   64'(bus.zero),      64'd0);
    end
    bus.in_valid = 1'b0;
    step();
    check("sll_drain", 64'(bus.out_valid), 64'd0);

    issue("add_acc", 32'h7FFF_FFFF, 32'd1, 5'd0, OP_ADD);
    check("add_res", 64'(bus.resultado), 64'h8000_0000);
    check("add_ovf", 64'(bus.overflow),  64'd1);
    check("add_z",   64'(bus.zero),      64'd0);

    issue("sub_acc", 32'd0, 32'd0, 5'd0, OP_SUB);
    check("sub_res", 64'(bus.resultado), 64'd0);
    check("sub_z",   64'(bus.zero),      64'd1);
    check("sub_ovf", 64'(bus.overflow),  64'd0);

    issue("mul_acc", 32'hFFFF_FFFF, 32'd2, 5'd0, OP_MULTU);
    bad = 0;
    for (int i = 1; i < W; i++) begin
      if (bus.in_ready !== 1'b0 || (i > 1 && bus.out_valid !== 1'b0)) bad++;
      step();
    end
    if (bus.in_ready !== 1'b0) bad++;
    check("mul_busy", 64'(bad), 64'd0);
    step();
    check("mul_vld", 64'(bus.out_valid),    64'd1);
    check("mul_hi",  64'(bus.resultado_hi), 64'd1);
    check("mul_lo",  64'(bus.resultado),    64'hFFFF_FFFE);
    check("mul_ovf", 64'(bus.overflow),     64'd0);

    issue("rsv_acc", 32'd5, 32'd3, 5'd0, 4'b1110);
    check("rsv_ill", 64'(bus.illegal),      64'd1);
    check("rsv_res", 64'(bus.resultado),    64'd0);
    check("rsv_z",   64'(bus.zero),         64'd1);
    check("rsv_hi",  64'(bus.resultado_hi), 64'd0);
    step();

    // Backpressure with a queued OR
    bus.out_ready = 1'b0;
    and_res = 32'hF0F0_F0F0 & 32'hFF00_FF00;
    issue("bp_acc", 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, OP_AND);
    drive(32'h0000_00F0, 32'h0000_000F, 5'd0, OP_OR);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.resultado !== and_res || bus.in_ready !== 1'b0) bad++;
      step();
    end
    check("bp_hold", 64'(bad), 64'd0);
    check("bp_res",  64'(bus.resultado), 64'(and_res));
    bus.out_ready = 1'b1;
    #1;
    check("bp_rdy", 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_or_vld", 64'(bus.out_valid), 64'd1);
    check("bp_or_res", 64'(bus.resultado), 64'h0000_00FF);
    step();
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a multiply
    issue("rm_acc", 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, OP_MULTU);
    for (int i = 0; i < 9; i++) step();
    #2;
    reset = 1'b1;
    #1;
    check("rm_vld", 64'(bus.out_valid), 64'd0);
    check("rm_rdy", 64'(bus.in_ready),  64'd0);
    step();
    step();
    reset = 1'b0;
    step();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      step();
    end
    check("rm_no_vld", 64'(seen), 64'd0);
    issue("slt_acc", 32'hFFFF_FFFF, 32'd0, 5'd0, OP_SLT);
    check("slt_res", 64'(bus.resultado), 64'd1);
    step();

    // Randomized traffic
    took = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.in_valid || took) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.a_input  = pick();
        bus.b_input  = pick();
        bus.sa       = 5'($urandom_range(0, 31));
        bus.opcode   = 4'($urandom_range(0, 15));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      sb_cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) sb_cycle();
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
